// File: rtl/bus_controller_rr.sv
// Shared serial-bus arbiter: fixed-priority or round-robin grant with start
// timeout, max-hold preemption and saturating utilisation/grant statistics.
module bus_controller_rr #(
  parameter int unsigned NUM_MASTERS   = 12,
  parameter int unsigned MID_WIDTH     = 4,
  parameter int unsigned START_TIMEOUT = 16,
  parameter int unsigned MAX_HOLD      = 64,
  parameter int unsigned STAT_WIDTH    = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NUM_MASTERS-1:0] m_reqs,
  output logic [NUM_MASTERS-1:0] m_grants,
  input  logic                   bus_util,
  input  logic                   rr_mode,
  input  logic                   preempt_en,
  input  logic                   clr_stats,
  output logic [2:0]             state,
  output logic [MID_WIDTH-1:0]   mid_current,
  output logic                   timeout_pulse,
  output logic                   preempt_pulse,
  output logic [STAT_WIDTH-1:0]  busy_cycles,
  output logic [STAT_WIDTH-1:0]  grant_count
);

  localparam int unsigned TO_W  = $clog2(START_TIMEOUT);
  localparam int unsigned MH_W  = $clog2(MAX_HOLD);
  localparam int unsigned CNT_W = (TO_W > MH_W) ? TO_W : MH_W;
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(START_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GRANT   = 3'd1,
    ST_BUSY    = 3'd2,
    ST_RELEASE = 3'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grants_q, grants_d;
  logic [MID_WIDTH-1:0]   mid_q, mid_d;
  logic [MID_WIDTH-1:0]   last_q, last_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   tp_q, tp_d;
  logic                   pp_q, pp_d;
  logic [STAT_WIDTH-1:0]  busy_q, busy_d;
  logic [STAT_WIDTH-1:0]  gcnt_q, gcnt_d;
  logic                   grant_inc;

  logic [MID_WIDTH-1:0]   fix_w, hi_w, win_w;
  logic                   hi_found;
  logic                   cur_req, other_req;

  // Lowest requester overall, and lowest requester above the last winner (RR wrap)
  always_comb begin
    fix_w    = '0;
    hi_w     = '0;
    hi_found = 1'b0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (m_reqs[i]) begin
        fix_w = MID_WIDTH'(i);
        if (MID_WIDTH'(i) > last_q) begin
          hi_w     = MID_WIDTH'(i);
          hi_found = 1'b1;
        end
      end
    end
    win_w = (rr_mode && hi_found) ? hi_w : fix_w;
  end

  assign cur_req   = |(m_reqs & grants_q);
  assign other_req = |(m_reqs & ~grants_q);

  always_comb begin
    state_d   = state_q;
    grants_d  = grants_q;
    mid_d     = mid_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    tp_d      = 1'b0;
    pp_d      = 1'b0;
    grant_inc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        grants_d = '0;
        if (|m_reqs) begin
          state_d   = ST_GRANT;
          grants_d  = NUM_MASTERS'(1) << win_w;
          mid_d     = win_w;
          cnt_d     = '0;
          grant_inc = 1'b1;
        end
      end
      ST_GRANT: begin
        if (!bus_util) begin
          state_d = ST_BUSY;
          cnt_d   = '0;
        end else if (!cur_req || (cnt_q == TO_LAST)) begin
          state_d  = ST_RELEASE;
          grants_d = '0;
          last_d   = mid_q;
          tp_d     = cur_req;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_BUSY: begin
        if (bus_util || !cur_req) begin
          state_d  = ST_RELEASE;
          grants_d = '0;
          last_d   = mid_q;
        end else if (preempt_en && (cnt_q == HOLD_LAST) && other_req) begin
          state_d  = ST_RELEASE;
          grants_d = '0;
          last_d   = mid_q;
          pp_d     = 1'b1;
        end else if (cnt_q != HOLD_LAST) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RELEASE: begin
        grants_d = '0;
        if (bus_util) state_d = ST_IDLE;
      end
      default: begin
        state_d  = ST_IDLE;
        grants_d = '0;
        cnt_d    = '0;
      end
    endcase
  end

  // Saturating statistics; clear wins over increment
  always_comb begin
    busy_d = busy_q;
    gcnt_d = gcnt_q;
    if (clr_stats) begin
      busy_d = '0;
      gcnt_d = '0;
    end else begin
      if (!bus_util && (busy_q != '1)) busy_d = busy_q + STAT_WIDTH'(1);
      if (grant_inc && (gcnt_q != '1)) gcnt_d = gcnt_q + STAT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      grants_q <= '0;
      mid_q    <= '0;
      last_q   <= MID_WIDTH'(NUM_MASTERS - 1);
      cnt_q    <= '0;
      tp_q     <= 1'b0;
      pp_q     <= 1'b0;
      busy_q   <= '0;
      gcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      grants_q <= grants_d;
      mid_q    <= mid_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      tp_q     <= tp_d;
      pp_q     <= pp_d;
      busy_q   <= busy_d;
      gcnt_q   <= gcnt_d;
    end
  end

  assign state         = state_q;
  assign m_grants      = grants_q;
  assign mid_current   = mid_q;
  assign timeout_pulse = tp_q;
  assign preempt_pulse = pp_q;
  assign busy_cycles   = busy_q;
  assign grant_count   = gcnt_q;

endmodule

// File: tb/tb_bus_controller_rr.sv
// Bench for bus_controller_rr: rule-level arbitration model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_bus_controller_rr;

  localparam int unsigned N  = 12;
  localparam int unsigned ST = 16;
  localparam int unsigned MH = 64;
  localparam int MAX16 = 65535;
  localparam int MAX4  = 15;

  logic          clk = 1'b0;
  logic          rstn;
  logic [N-1:0]  m_reqs;
  logic          bus_util, rr_mode, preempt_en, clr_stats;

  logic [N-1:0]  m_grants, m_grants4;
  logic [2:0]    state, state4;
  logic [3:0]    mid_current, mid_current4;
  logic          timeout_pulse, preempt_pulse, timeout_pulse4, preempt_pulse4;
  logic [15:0]   busy_cycles, grant_count;
  logic [3:0]    busy_cycles4, grant_count4;

  bus_controller_rr #(.NUM_MASTERS(N), .MID_WIDTH(4), .START_TIMEOUT(ST),
                      .MAX_HOLD(MH), .STAT_WIDTH(16)) u_dut (
    .clk(clk), .rstn(rstn), .m_reqs(m_reqs), .m_grants(m_grants),
    .bus_util(bus_util), .rr_mode(rr_mode), .preempt_en(preempt_en),
    .clr_stats(clr_stats), .state(state), .mid_current(mid_current),
    .timeout_pulse(timeout_pulse), .preempt_pulse(preempt_pulse),
    .busy_cycles(busy_cycles), .grant_count(grant_count));

  bus_controller_rr #(.NUM_MASTERS(N), .MID_WIDTH(4), .START_TIMEOUT(ST),
                      .MAX_HOLD(MH), .STAT_WIDTH(4)) u_dut4 (
    .clk(clk), .rstn(rstn), .m_reqs(m_reqs), .m_grants(m_grants4),
    .bus_util(bus_util), .rr_mode(rr_mode), .preempt_en(preempt_en),
    .clr_stats(clr_stats), .state(state4), .mid_current(mid_current4),
    .timeout_pulse(timeout_pulse4), .preempt_pulse(preempt_pulse4),
    .busy_cycles(busy_cycles4), .grant_count(grant_count4));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: spec state codes, winner, age in current state, statistics
  int m_st, m_gr, m_mid, m_last, m_age, m_tp, m_pp;
  int m_busy, m_gc, m_busy4, m_gc4;
  int rq, cur, oth, granted;

  function automatic int pick(input int req, input int last, input bit rr);
    if (rr) begin
      for (int k = 1; k <= int'(N); k++) begin
        int idx = (last + k) % int'(N);
        if (((req >> idx) & 1) == 1) return idx;
      end
    end
    for (int i = 0; i < int'(N); i++)
      if (((req >> i) & 1) == 1) return i;
    return 0;
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_st = 0; m_gr = 0; m_mid = 0; m_last = int'(N) - 1; m_age = 0;
      m_tp = 0; m_pp = 0; m_busy = 0; m_gc = 0; m_busy4 = 0; m_gc4 = 0;
    end else begin
      rq      = int'(m_reqs);
      cur     = (rq >> m_mid) & 1;
      oth     = ((rq & ~(1 << m_mid)) != 0) ? 1 : 0;
      granted = 0;
      m_tp    = 0;
      m_pp    = 0;
      m_age   = m_age + 1;
      case (m_st)
        0: if (rq != 0) begin
             m_mid = pick(rq, m_last, rr_mode);
             m_gr = 1 << m_mid; m_st = 1; m_age = 0; granted = 1;
           end
        1: if (!bus_util) begin
             m_st = 2; m_age = 0;
           end else if (cur == 0 || m_age == int'(ST)) begin
             m_tp = cur; m_st = 3; m_gr = 0; m_last = m_mid;
           end
        2: if (bus_util || cur == 0) begin
             m_st = 3; m_gr = 0; m_last = m_mid;
           end else if (preempt_en && oth == 1 && m_age >= int'(MH)) begin
             m_pp = 1; m_st = 3; m_gr = 0; m_last = m_mid;
           end
        default: if (bus_util) m_st = 0;
      endcase
      if (clr_stats) begin
        m_busy = 0; m_busy4 = 0; m_gc = 0; m_gc4 = 0;
      end else begin
        if (!bus_util) begin
          m_busy  = sat(m_busy + 1, MAX16);
          m_busy4 = sat(m_busy4 + 1, MAX4);
        end
        m_gc  = sat(m_gc + granted, MAX16);
        m_gc4 = sat(m_gc4 + granted, MAX4);
      end
    end
  end

  // Cycle-by-cycle comparison away from the active edge
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("state", int'(state), m_st);
      chk("m_grants", int'(m_grants), m_gr);
      chk("mid_current", int'(mid_current), m_mid);
      chk("timeout_pulse", int'(timeout_pulse), m_tp);
      chk("preempt_pulse", int'(preempt_pulse), m_pp);
      chk("busy_cycles", int'(busy_cycles), m_busy);
      chk("grant_count", int'(grant_count), m_gc);
      chk("state_w4", int'(state4), m_st);
      chk("m_grants_w4", int'(m_grants4), m_gr);
      chk("mid_current_w4", int'(mid_current4), m_mid);
      chk("timeout_pulse_w4", int'(timeout_pulse4), m_tp);
      chk("preempt_pulse_w4", int'(preempt_pulse4), m_pp);
      chk("busy_cycles_w4", int'(busy_cycles4), m_busy4);
      chk("grant_count_w4", int'(grant_count4), m_gc4);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int rr_exp [4] = '{0, 1, 3, 0};

  initial begin
    rstn = 1'b0; m_reqs = '0; bus_util = 1'b1; rr_mode = 1'b0;
    preempt_en = 1'b0; clr_stats = 1'b0;
    step(2);
    chk("rst_state", int'(state), 0);
    chk("rst_grants", int'(m_grants), 0);
    chk("rst_mid", int'(mid_current), 0);
    chk("rst_busy", int'(busy_cycles), 0);
    chk("rst_gcnt", int'(grant_count), 0);
    cmp_en = 1'b1;

    // Fixed priority
    rstn = 1'b1; m_reqs = 12'h028;
    step(1);
    chk("fix_grant", int'(m_grants), 'h008);
    chk("fix_mid", int'(mid_current), 3);
    chk("fix_state_grant", int'(state), 1);
    step(2); bus_util = 1'b0;
    step(1);
    chk("fix_state_busy", int'(state), 2);
    step(3);
    chk("fix_busy_cycles", int'(busy_cycles), 4);
    bus_util = 1'b1;
    step(1);
    chk("fix_release", int'(state), 3);
    chk("fix_release_grants", int'(m_grants), 0);
    step(2);
    chk("fix_regrant", int'(m_grants), 'h008);
    m_reqs = 12'h020;
    step(1);
    chk("fix_withdraw", int'(state), 3);
    step(2);
    chk("fix_next", int'(m_grants), 'h020);
    chk("fix_gcnt", int'(grant_count), 3);
    m_reqs = '0;
    step(2);

    // Round-robin order
    clr_stats = 1'b1;
    step(1);
    clr_stats = 1'b0; rr_mode = 1'b1; m_reqs = 12'h00B;
    step(1);
    for (int g = 0; g < 4; g++) begin
      chk("rr_mid", int'(mid_current), rr_exp[g]);
      chk("rr_state", int'(state), 1);
      if (g < 3) begin
        bus_util = 1'b0; step(2);
        bus_util = 1'b1; step(3);
      end
    end
    chk("rr_gcnt", int'(grant_count), 4);
    m_reqs = '0;
    step(2);

    // Start timeout
    rr_mode = 1'b0; m_reqs = 12'h020;
    step(1);
    chk("to_grant", int'(m_grants), 'h020);
    step(15);
    chk("to_still_grant", int'(state), 1);
    chk("to_no_pulse_yet", int'(timeout_pulse), 0);
    m_reqs = 12'h021;
    step(1);
    chk("to_state", int'(state), 3);
    chk("to_pulse", int'(timeout_pulse), 1);
    chk("to_grants", int'(m_grants), 0);
    step(1);
    chk("to_idle", int'(state), 0);
    chk("to_pulse_gone", int'(timeout_pulse), 0);
    step(1);
    chk("to_next_winner", int'(m_grants), 'h001);
    m_reqs = '0;
    step(2);

    // Preemption
    rr_mode = 1'b1; preempt_en = 1'b1; m_reqs = 12'h004;
    step(1);
    chk("pre_grant", int'(m_grants), 'h004);
    bus_util = 1'b0;
    step(1);
    chk("pre_busy", int'(state), 2);
    m_reqs = 12'h014;
    step(63);
    chk("pre_hold63", int'(state), 2);
    chk("pre_no_pulse", int'(preempt_pulse), 0);
    step(1);
    chk("pre_state", int'(state), 3);
    chk("pre_pulse", int'(preempt_pulse), 1);
    chk("pre_grants", int'(m_grants), 0);
    step(2);
    chk("pre_wait_float", int'(state), 3);
    chk("pre_pulse_gone", int'(preempt_pulse), 0);
    bus_util = 1'b1;
    step(2);
    chk("pre_next_grant", int'(m_grants), 'h010);
    chk("pre_next_mid", int'(mid_current), 4);
    bus_util = 1'b0;
    step(1);
    preempt_en = 1'b0;
    step(100);
    chk("nopre_state", int'(state), 2);
    chk("nopre_grants", int'(m_grants), 'h010);

    // Asynchronous reset mid-BUSY
    rstn = 1'b0;
    #1;
    chk("arst_grants", int'(m_grants), 0);
    chk("arst_state", int'(state), 0);
    chk("arst_mid", int'(mid_current), 0);
    chk("arst_busy", int'(busy_cycles), 0);
    chk("arst_gcnt", int'(grant_count), 0);
    step(1);
    rstn = 1'b1; bus_util = 1'b1; m_reqs = 12'h011;
    step(1);
    chk("arst_rr_restart", int'(m_grants), 'h001);
    chk("arst_gcnt_after", int'(grant_count), 1);
    m_reqs = '0;
    step(2);

    // Statistics and saturation
    clr_stats = 1'b1;
    step(1);
    clr_stats = 1'b0; bus_util = 1'b0;
    step(10);
    chk("stat_busy10", int'(busy_cycles), 10);
    chk("stat_busy10_w4", int'(busy_cycles4), 10);
    step(20);
    chk("stat_busy30", int'(busy_cycles), 30);
    chk("stat_sat_w4", int'(busy_cycles4), 15);
    clr_stats = 1'b1;
    step(1);
    chk("stat_clr_busy", int'(busy_cycles), 0);
    chk("stat_clr_w4", int'(busy_cycles4), 0);
    clr_stats = 1'b0; bus_util = 1'b1;
    step(2);

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
